rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 32-bit datapath mux (e.g. a common memory/writeback port) among four requesters.
- Produces a one-hot grant and the 2-bit mux select.
- Registers the selected data word for the downstream stage.
- Sits between the requesting pipeline units and the shared resource. Owns the select line, so no other logic drives the mux select.

Parameters:
- DATA_WIDTH, 32, width of each data input and of OutData
- MAX_HOLD, 16, cycles an owner may hold the grant before forced release (used only with ARB_TIMEOUT_EN); legal 2..255

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous reset, active-low (Rst==0 at a rising edge resets)
- Req  input  4  request per requester; bit i = requester i; level-sensitive, held for as long as access is wanted
- InA  input  DATA_WIDTH  data of requester 0
- InB  input  DATA_WIDTH  data of requester 1
- InC  input  DATA_WIDTH  data of requester 2
- InD  input  DATA_WIDTH  data of requester 3
- Grant  output  4  one-hot grant, registered
- Sel  output  2  encoded index of the owner, registered; drives the shared mux
- Busy  output  1  1 while any grant is active (Busy == |Grant)
- OutData  output  DATA_WIDTH  registered copy of the selected input
- OutValid  output  1  OutData holds a word captured under a grant
- TimeoutPulse  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset values (Rst==0 at an edge, in any state, including mid-grant):
  - Grant=0, Sel=0, Busy=0, OutData=0, OutValid=0, TimeoutPulse=0
  - Priority pointer ptr=0; hold counter=0; state=IDLE
- Two states: IDLE, OWN.
- Arbitration function:
  - Scan Req circularly starting at ptr (ptr, ptr+1, ... mod 4).
  - The first set bit wins.
  - Pure combinational pick; the result is registered.
- IDLE:
  - If Req==0: stay IDLE.
  - Otherwise, next edge: Grant=onehot(winner), Sel=winner, Busy=1, go to OWN.
  - Latency Req -> Grant is exactly 1 cycle.
- OWN, owner o=Sel:
  - Release condition: Req[o]==0 at an edge.
  - On release: ptr <= o+1 mod 4.
    - Same edge, if any other Req bit is set: arbitrate with the new ptr and grant directly (zero dead cycles on handoff); stay OWN.
    - Else: Grant=0, Busy=0, go to IDLE.
  - While Req[o]==1 and no timeout: grant held; other requests wait.
- Simultaneous events:
  - Owner drops while others rise in the same cycle: handoff per rule above.
  - Multiple new requests: round-robin order from ptr; no requester is granted twice while another waits (fairness bound 3 grants).
- Data path:
  - Each edge with Grant!=0: OutData <= input selected by current Sel (0:InA, 1:InB, 2:InC, 3:InD); OutValid <= 1.
  - Each edge with Grant==0: OutData holds its value; OutValid <= 0.
  - OutData lags Sel by 1 cycle.
- Invariants:
  - Grant is always zero or one-hot.
  - Sel == index of the Grant bit when Busy.
  - Sel holds its last value when idle.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each OWN cycle.
  - When the counter reaches MAX_HOLD-1 with Req[o] still 1: forced release.
    - ptr <= o+1.
    - Arbitrate among Req with bit o masked. If the masked Req is zero, re-grant o and clear the counter.
    - TimeoutPulse=1 for that one cycle.
- Not defined: no counter; the grant is held indefinitely while Req[o]==1; TimeoutPulse tied to 0.

Test Plan:
- Reset then Req=4'b0000 for 5 cycles -> Grant=0, Sel=0, Busy=0, OutValid=0, OutData=0 throughout.
- Req=4'b0100 at cycle 0, InC=32'hDEADBEEF -> cycle 1 Grant=4'b0100, Sel=2; cycle 2 OutData=32'hDEADBEEF, OutValid=1.
- Req=4'b1111 constant, each owner drops its Req for one cycle after 2 grant cycles and then reasserts -> grant order 0,1,2,3,0 with no idle cycle between owners.
- Owner 1 holds, Req[1] drops in the same cycle Req[3] and Req[0] rise -> next edge Grant=4'b1000 (ptr=2 scans 2,3), then 0 after 3 releases.
- Rst=0 asserted during OWN with Grant=4'b0010 -> next edge all outputs zero, state IDLE; after Rst=1 with Req=4'b0011 -> Grant=4'b0001 (ptr back to 0).
- ARB_TIMEOUT_EN, MAX_HOLD=4, Req=4'b0101 held -> requester 0 owns 4 cycles, TimeoutPulse=1 once, Grant=4'b0100; without the macro -> requester 0 holds forever, TimeoutPulse=0.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 datapath mux; registers grant, select and data.
// Optional forced release after MAX_HOLD owner cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_mux_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [3:0]            Req,
  input  logic [DATA_WIDTH-1:0] InA,
  input  logic [DATA_WIDTH-1:0] InB,
  input  logic [DATA_WIDTH-1:0] InC,
  input  logic [DATA_WIDTH-1:0] InD,
  output logic [3:0]            Grant,
  output logic [1:0]            Sel,
  output logic                  Busy,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic                  OutValid,
  output logic                  TimeoutPulse
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 32'd1);

  // Returns {found, index}; scans req circularly from start, lowest offset wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_t                state_r, state_n;
  logic [1:0]            ptr_r, ptr_n;
  logic [3:0]            grant_r, grant_n;
  logic [1:0]            sel_r, sel_n;
  logic                  busy_r;
  logic [7:0]            hold_r, hold_n;
  logic                  tpulse_r, tpulse_n;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] mux_s;
  logic [1:0]            next_ptr_s;
  logic [2:0]            pick_s;

  assign Grant        = grant_r;
  assign Sel          = sel_r;
  assign Busy         = busy_r;
  assign OutData      = out_data_r;
  assign OutValid     = out_valid_r;
  assign TimeoutPulse = tpulse_r;

  // Next-state, grant and pointer decision.
  always_comb begin
    state_n    = state_r;
    ptr_n      = ptr_r;
    grant_n    = grant_r;
    sel_n      = sel_r;
    hold_n     = hold_r;
    tpulse_n   = 1'b0;
    next_ptr_s = sel_r + 2'd1;
    pick_s     = 3'b000;
    case (state_r)
      IDLE: begin
        pick_s = rr_pick(Req, ptr_r);
        if (pick_s[2]) begin
          grant_n = onehot(pick_s[1:0]);
          sel_n   = pick_s[1:0];
          hold_n  = 8'd0;
          state_n = OWN;
        end else begin
          grant_n = 4'b0000;
          hold_n  = 8'd0;
        end
      end
      OWN: begin
        if (!Req[sel_r]) begin
          // Release: hand off on the same edge when anyone else is waiting.
          ptr_n  = next_ptr_s;
          pick_s = rr_pick(Req, next_ptr_s);
          hold_n = 8'd0;
          if (pick_s[2]) begin
            grant_n = onehot(pick_s[1:0]);
            sel_n   = pick_s[1:0];
          end else begin
            grant_n = 4'b0000;
            state_n = IDLE;
          end
        end else if (TIMEOUT_EN && (hold_r == HOLD_LAST)) begin
          // Forced release; the owner is re-granted only if nobody else asks.
          ptr_n    = next_ptr_s;
          pick_s   = rr_pick(Req & ~onehot(sel_r), next_ptr_s);
          hold_n   = 8'd0;
          tpulse_n = 1'b1;
          if (pick_s[2]) begin
            grant_n = onehot(pick_s[1:0]);
            sel_n   = pick_s[1:0];
          end else begin
            grant_n = onehot(sel_r);
          end
        end else begin
          hold_n = TIMEOUT_EN ? (hold_r + 8'd1) : 8'd0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 4'b0000;
        hold_n  = 8'd0;
      end
    endcase
  end

  // Shared mux driven by the registered select.
  always_comb begin
    mux_s = InA;
    case (sel_r)
      2'd0:    mux_s = InA;
      2'd1:    mux_s = InB;
      2'd2:    mux_s = InC;
      2'd3:    mux_s = InD;
      default: mux_s = InA;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r  <= IDLE;
      ptr_r    <= 2'd0;
      grant_r  <= 4'b0000;
      sel_r    <= 2'd0;
      busy_r   <= 1'b0;
      hold_r   <= 8'd0;
      tpulse_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      ptr_r    <= ptr_n;
      grant_r  <= grant_n;
      sel_r    <= sel_n;
      busy_r   <= |grant_n;
      hold_r   <= hold_n;
      tpulse_r <= tpulse_n;
    end
  end

  // Output data capture; lags the select by one cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (grant_r != 4'b0000) begin
      out_data_r  <= mux_s;
      out_valid_r <= 1'b1;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (MAX_HOLD=4); timeout checks follow ARB_TIMEOUT_EN.
module tb_rr_mux_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [3:0]  Req = 4'b0000;
  logic [31:0] InA = 32'hA0A0_0000;
  logic [31:0] InB = 32'hB1B1_1111;
  logic [31:0] InC = 32'hC2C2_2222;
  logic [31:0] InD = 32'hD3D3_3333;
  logic [3:0]  Grant;
  logic [1:0]  Sel;
  logic        Busy;
  logic [31:0] OutData;
  logic        OutValid;
  logic        TimeoutPulse;

  int checks = 0;
  int failures = 0;

  rr_mux_arbiter #(.DATA_WIDTH(32), .MAX_HOLD(4)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req),
    .InA(InA), .InB(InB), .InC(InC), .InD(InD),
    .Grant(Grant), .Sel(Sel), .Busy(Busy),
    .OutData(OutData), .OutValid(OutValid), .TimeoutPulse(TimeoutPulse)
  );

  always #5 Clk = ~Clk;

  task tick;
    @(posedge Clk);
    #1;
  endtask

  task do_reset;
    Rst = 1'b0;
    Req = 4'b0000;
    tick;
    tick;
    Rst = 1'b1;
  endtask

  task test_reset;
    do_reset;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if ({Grant, Sel, Busy, OutValid, TimeoutPulse, OutData} !== 41'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got G=%b S=%0d B=%b V=%b T=%b D=%h want all zero",
                 i, Grant, Sel, Busy, OutValid, TimeoutPulse, OutData);
      end
    end
  endtask

  task test_single;
    do_reset;
    InC = 32'hDEADBEEF;
    Req = 4'b0100;
    tick;
    checks++;
    if ({Grant, Sel, Busy, OutValid} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_grant got G=%b S=%0d B=%b V=%b want G=0100 S=2 B=1 V=0", Grant, Sel, Busy, OutValid);
    end
    tick;
    checks++;
    if ({OutData, OutValid} !== {32'hDEADBEEF, 1'b1}) begin
      failures++;
      $display("FAIL single_data got D=%h V=%b want D=deadbeef V=1", OutData, OutValid);
    end
    Req = 4'b0000;
    tick;
    checks++;
    if ({Grant, Busy} !== {4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL single_release got G=%b B=%b want G=0000 B=0", Grant, Busy);
    end
    tick;
    checks++;
    if ({Sel, OutValid, OutData} !== {2'd2, 1'b0, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL single_idle_hold got S=%0d V=%b D=%h want S=2 V=0 D=deadbeef", Sel, OutValid, OutData);
    end
  endtask

  task test_rotation;
    logic [31:0] dv [4];
    logic [3:0]  exp_g;
    dv[0] = InA; dv[1] = InB; dv[2] = InC; dv[3] = InD;
    do_reset;
    Req = 4'b1111;
    tick;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      Req = 4'b1111;
      checks++;
      if ({Grant, Sel, Busy} !== {exp_g, 2'(k % 4), 1'b1}) begin
        failures++;
        $display("FAIL rotation_grant k=%0d got G=%b S=%0d B=%b want G=%b S=%0d B=1", k, Grant, Sel, Busy, exp_g, k % 4);
      end
      tick;
      checks++;
      if ({Grant, OutData, OutValid} !== {exp_g, dv[k % 4], 1'b1}) begin
        failures++;
        $display("FAIL rotation_hold k=%0d got G=%b D=%h V=%b want G=%b D=%h V=1", k, Grant, OutData, OutValid, exp_g, dv[k % 4]);
      end
      Req = 4'b1111 & ~exp_g;
      tick;
    end
  endtask

  task test_handoff;
    do_reset;
    Req = 4'b0010;
    tick;
    tick;
    checks++;
    if ({Grant, Sel} !== {4'b0010, 2'd1}) begin
      failures++;
      $display("FAIL handoff_owner1 got G=%b S=%0d want G=0010 S=1", Grant, Sel);
    end
    Req = 4'b1001;
    tick;
    checks++;
    if ({Grant, Sel, Busy} !== {4'b1000, 2'd3, 1'b1}) begin
      failures++;
      $display("FAIL handoff_to3 got G=%b S=%0d B=%b want G=1000 S=3 B=1", Grant, Sel, Busy);
    end
    Req = 4'b0001;
    tick;
    checks++;
    if ({Grant, Sel, Busy} !== {4'b0001, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL handoff_to0 got G=%b S=%0d B=%b want G=0001 S=0 B=1", Grant, Sel, Busy);
    end
    Req = 4'b0000;
    tick;
    checks++;
    if ({Grant, Sel, Busy} !== {4'b0000, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL handoff_idle got G=%b S=%0d B=%b want G=0000 S=0 B=0", Grant, Sel, Busy);
    end
  endtask

  task test_reset_mid;
    do_reset;
    InB = 32'h1234_5678;
    Req = 4'b0010;
    tick;
    tick;
    checks++;
    if ({Grant, OutData, OutValid} !== {4'b0010, 32'h1234_5678, 1'b1}) begin
      failures++;
      $display("FAIL midreset_pre got G=%b D=%h V=%b want G=0010 D=12345678 V=1", Grant, OutData, OutValid);
    end
    Rst = 1'b0;
    tick;
    checks++;
    if ({Grant, Sel, Busy, OutValid, TimeoutPulse, OutData} !== 41'd0) begin
      failures++;
      $display("FAIL midreset_clear got G=%b S=%0d B=%b V=%b T=%b D=%h want all zero",
               Grant, Sel, Busy, OutValid, TimeoutPulse, OutData);
    end
    Rst = 1'b1;
    Req = 4'b0011;
    tick;
    checks++;
    if ({Grant, Sel, Busy} !== {4'b0001, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL midreset_ptr got G=%b S=%0d B=%b want G=0001 S=0 B=1", Grant, Sel, Busy);
    end
  endtask

  task test_timeout;
    do_reset;
    Req = 4'b0101;
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({Grant, TimeoutPulse} !== {4'b0001, 1'b0}) begin
        failures++;
        $display("FAIL timeout_own cyc=%0d got G=%b T=%b want G=0001 T=0", i, Grant, TimeoutPulse);
      end
      tick;
    end
`ifdef ARB_TIMEOUT_EN
    checks++;
    if ({Grant, Sel, TimeoutPulse} !== {4'b0100, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL timeout_force got G=%b S=%0d T=%b want G=0100 S=2 T=1", Grant, Sel, TimeoutPulse);
    end
    tick;
    checks++;
    if ({Grant, TimeoutPulse} !== {4'b0100, 1'b0}) begin
      failures++;
      $display("FAIL timeout_pulse_once got G=%b T=%b want G=0100 T=0", Grant, TimeoutPulse);
    end
    do_reset;
    Req = 4'b0001;
    for (int i = 0; i < 5; i++) tick;
    checks++;
    if ({Grant, TimeoutPulse} !== {4'b0001, 1'b1}) begin
      failures++;
      $display("FAIL timeout_regrant got G=%b T=%b want G=0001 T=1", Grant, TimeoutPulse);
    end
`else
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({Grant, TimeoutPulse} !== {4'b0001, 1'b0}) begin
        failures++;
        $display("FAIL timeout_none cyc=%0d got G=%b T=%b want G=0001 T=0", i, Grant, TimeoutPulse);
      end
      tick;
    end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_rotation;
    test_handoff;
    test_reset_mid;
    test_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
